// File: rtl/instr_mem_loader.sv
// Program-image loader: frames a host byte stream, assembles big-endian words,
// writes them to instruction memory and releases the core once the XOR checksum matches.
module instr_mem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    // state  | meaning
    // IDLE   | waiting for SYNC_BYTE after reset
    // CNT_HI | expecting word-count high byte
    // CNT_LO | expecting word-count low byte, size check
    // DATA   | assembling and writing data words
    // CHECK  | expecting checksum byte
    // DONE   | image good, core released; SYNC restarts
    // ERR    | framing/size/checksum error; SYNC restarts
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CNT_HI = 3'd1;
    localparam logic [2:0] ST_CNT_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    logic [2:0]        r_state;
    logic [7:0]        r_cnt_hi;
    logic [15:0]       r_words_left;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_asm;
    logic [7:0]        r_xor;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_accept;
    logic              w_is_sync;
    logic [15:0]       w_count;

    assign in_ready  = 1'b1;
    assign w_accept  = in_valid && in_ready;
    assign w_is_sync = (in_data == SYNC_BYTE);
    assign w_count   = {r_cnt_hi, in_data};

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = (r_state != ST_DONE);
    assign load_done = (r_state == ST_DONE);
    assign load_err  = (r_state == ST_ERR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt_hi     <= 8'd0;
            r_words_left <= 16'd0;
            r_byte_idx   <= 2'd0;
            r_asm        <= 24'd0;
            r_xor        <= 8'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
        end else begin
            r_mem_we <= 1'b0;
            // Advance only after a non-final word; the last address is held so a full memory never wraps.
            if (r_mem_we && (r_state == ST_DATA)) begin
                r_mem_addr <= r_mem_addr + 1'b1;
            end

            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_is_sync) begin
                            r_state <= ST_CNT_HI;
                        end
                    end
                    ST_CNT_HI: begin
                        r_cnt_hi <= in_data;
                        r_state  <= ST_CNT_LO;
                    end
                    ST_CNT_LO: begin
                        r_words_left <= w_count;
                        r_mem_addr   <= '0;
                        r_byte_idx   <= 2'd0;
                        r_xor        <= 8'd0;
                        if ({1'b0, w_count} > MAX_WORDS) begin
                            r_state <= ST_ERR;
                        end else if (w_count == 16'd0) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        // Only three bytes need holding; the fourth comes straight off the bus.
                        r_asm      <= {r_asm[15:0], in_data};
                        r_xor      <= r_xor ^ in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_mem_we     <= 1'b1;
                            r_mem_wdata  <= {r_asm, in_data};
                            r_words_left <= r_words_left - 16'd1;
                            if (r_words_left == 16'd1) begin
                                r_state <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        r_state <= (in_data == r_xor) ? ST_DONE : ST_ERR;
                    end
                    ST_DONE, ST_ERR: begin
                        if (w_is_sync) begin
                            r_state <= ST_CNT_HI;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: scoreboard of expected memory writes
// plus per-scenario status checks.
module tb_instr_mem_loader;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] tx_words[$];
    int          checks;
    int          errors;
    int          wr_count;
    logic        prev_we;

    instr_mem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and act as the write monitor: every pulse is popped from the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) begin
            checks++;
            wr_count++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%08h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data || prev_we !== 1'b0) begin
                    errors++;
                    $display("FAIL write got addr=%0h data=%08h prev_we=%b expected addr=%0h data=%08h prev_we=0",
                             mem_addr, mem_wdata, prev_we, e.addr, e.data);
                end
            end
        end
        prev_we = mem_we;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
    endtask

    // Sends a full frame from tx_words; chk_delta corrupts the checksum when nonzero.
    task automatic send_frame(input int n, input logic [7:0] chk_delta, input int maxgap);
        logic [7:0]  x;
        logic [15:0] nn;
        logic [31:0] w;
        wr_t         e;
        x  = 8'h00;
        nn = n[15:0];
        send_byte(8'hA5);
        send_byte(nn[15:8]);
        send_byte(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            w      = tx_words[i];
            e.addr = i[ADDR_W-1:0];
            e.data = w;
            exp_q.push_back(e);
            for (int b = 3; b >= 0; b--) begin
                if (maxgap > 0) idle($urandom_range(0, maxgap));
                send_byte(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
        send_byte(x ^ chk_delta);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err} !==
            {1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b we=%b addr=%0h wd=%08h hold=%b done=%b err=%b expected 1 0 0 0 1 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err);
        end
    endtask

    task automatic test_basic();
        int w0;
        w0 = wr_count;
        tx_words = '{32'h11223344, 32'hAABBCCDD};
        send_frame(2, 8'h00, 0);
        checks++;
        if ({load_done, cpu_hold, load_err} !== 3'b100) begin
            errors++;
            $display("FAIL basic_status got done=%b hold=%b err=%b expected 1 0 0", load_done, cpu_hold, load_err);
        end
        checks++;
        if (wr_count - w0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_writes got %0d pending=%0d expected 2 pending=0", wr_count - w0, exp_q.size());
        end
    endtask

    task automatic test_bad_chk();
        int w0;
        w0 = wr_count;
        tx_words = '{32'h11223344, 32'hAABBCCDD};
        send_frame(2, 8'h01, 0);
        checks++;
        if ({load_done, cpu_hold, load_err} !== 3'b011 || wr_count - w0 != 2) begin
            errors++;
            $display("FAIL bad_chk got done=%b hold=%b err=%b writes=%0d expected 0 1 1 writes=2",
                     load_done, cpu_hold, load_err, wr_count - w0);
        end
        send_byte(8'hA5);
        checks++;
        if ({load_done, cpu_hold, load_err} !== 3'b010) begin
            errors++;
            $display("FAIL err_clear got done=%b hold=%b err=%b expected 0 1 0", load_done, cpu_hold, load_err);
        end
        apply_reset();
    endtask

    task automatic test_garbage_empty();
        int w0;
        w0 = wr_count;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        checks++;
        if ({load_done, cpu_hold, load_err} !== 3'b010) begin
            errors++;
            $display("FAIL garbage got done=%b hold=%b err=%b expected 0 1 0", load_done, cpu_hold, load_err);
        end
        tx_words.delete();
        send_frame(0, 8'h00, 0);
        checks++;
        if ({load_done, cpu_hold, load_err} !== 3'b100 || wr_count != w0) begin
            errors++;
            $display("FAIL empty_frame got done=%b hold=%b err=%b writes=%0d expected 1 0 0 writes=0",
                     load_done, cpu_hold, load_err, wr_count - w0);
        end
    endtask

    task automatic test_size();
        int w0;
        w0 = wr_count;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        checks++;
        if ({load_done, cpu_hold, load_err} !== 3'b011) begin
            errors++;
            $display("FAIL oversize got done=%b hold=%b err=%b expected 0 1 1", load_done, cpu_hold, load_err);
        end
        idle(3);
        checks++;
        if (wr_count != w0) begin
            errors++;
            $display("FAIL oversize_writes got %0d expected 0", wr_count - w0);
        end
        tx_words.delete();
        for (int i = 0; i < 256; i++) tx_words.push_back($urandom());
        send_frame(256, 8'h00, 0);
        checks++;
        if ({load_done, load_err} !== 2'b10 || mem_addr !== 8'hFF || wr_count - w0 != 256) begin
            errors++;
            $display("FAIL full_mem got done=%b err=%b addr=%0h writes=%0d expected 1 0 ff 256",
                     load_done, load_err, mem_addr, wr_count - w0);
        end
    endtask

    task automatic test_reset_mid();
        wr_t e;
        int  w0;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        e.addr = '0;
        e.data = 32'hDEADBEEF;
        exp_q.push_back(e);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h01); send_byte(8'h02);
        w0 = wr_count;
        apply_reset();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err} !==
            {1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got we=%b addr=%0h wd=%08h hold=%b done=%b err=%b expected 0 0 0 1 0 0",
                     mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err);
        end
        send_byte(8'h03);
        send_byte(8'h04);
        idle(3);
        checks++;
        if (wr_count != w0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_writes got %0d pending=%0d expected 0 pending=0", wr_count - w0, exp_q.size());
        end
        tx_words = '{32'hCAFEF00D, 32'h0BADC0DE};
        send_frame(2, 8'h00, 0);
        checks++;
        if ({load_done, load_err} !== 2'b10 || wr_count - w0 != 2) begin
            errors++;
            $display("FAIL reload got done=%b err=%b writes=%0d expected 1 0 2", load_done, load_err, wr_count - w0);
        end
    endtask

    task automatic test_gaps();
        int w0;
        w0 = wr_count;
        tx_words = '{32'h11223344, 32'hAABBCCDD, 32'hA5A5A5A5, 32'hA5000001, 32'h01020304};
        send_frame(5, 8'h00, 5);
        idle(2);
        checks++;
        if ({load_done, cpu_hold, load_err} !== 3'b100 || wr_count - w0 != 5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL gaps got done=%b hold=%b err=%b writes=%0d expected 1 0 0 writes=5",
                     load_done, cpu_hold, load_err, wr_count - w0);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wr_count = 0;
        prev_we  = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_bad_chk();
        test_garbage_empty();
        test_size();
        test_reset_mid();
        test_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
